// File: rtl/seq_scan_ctrl_pkg.sv
// Shared constants for the serial scan controller:
// FSM state encoding and default widths.
package seq_scan_ctrl_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int PAT_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/seq_scan_ctrl_match_core.sv
// Serial pattern matcher: bit history, fill count,
// combinational hit and registered match pulse.
module pattern_match_core
    import seq_scan_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_bit,
    input  logic             valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clear,
    output logic             hit,
    output logic             match
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_n;

    // Next history/fill and the hit on the bit being presented
    always_comb begin
        hist_n = {hist[PAT_W-2:0], data_bit};
        fill_n = (fill == FULL) ? FULL : fill + 1'b1;
        hit    = valid && (fill_n == FULL) && (hist_n == pattern);
    end

    // History update; a non-overlapping hit restarts the fill
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit;
            if (clear) begin
                hist <= '0;
                fill <= '0;
            end else if (valid) begin
                hist <= hist_n;
                fill <= (hit && !overlap) ? '0 : fill_n;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit scan controller: handshake, shifter, FSM,
// saturating match counter and sticky threshold flag.
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int PAT_W  = PAT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    input  logic              clr_count,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              thresh_hit,
    output logic              busy,
    output logic              done
);

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [1:0]        state;
    logic [WORD_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              last_q;
    logic              frame_open;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic              word_end;
    logic              accept;
    logic              hit;
    logic [CNT_W-1:0]  cnt_inc;

    // Handshake and status decode from the FSM state
    always_comb begin
        word_end  = (state == ST_SHIFT) && (bit_cnt == '0);
        s_ready   = reset && ((state == ST_IDLE) || (word_end && !last_q));
        accept    = s_valid && s_ready;
        bit_valid = (state == ST_SHIFT);
        bit_out   = shreg[WORD_W-1];
        busy      = (state != ST_IDLE);
        done      = (state == ST_FLUSH);
        cnt_inc   = match_count + 1'b1;
    end

    // FSM, shifter and config capture on the first word of a frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            last_q     <= 1'b0;
            frame_open <= 1'b0;
            pat_q      <= '0;
            ovl_q      <= 1'b0;
        end else if (accept) begin
            shreg      <= s_data;
            last_q     <= s_last;
            bit_cnt    <= BW'(WORD_W - 1);
            frame_open <= 1'b1;
            state      <= ST_SHIFT;
            if (!frame_open) begin
                pat_q <= cfg_pattern;
                ovl_q <= cfg_overlap;
            end
        end else begin
            unique case (1'b1)
                (state == ST_SHIFT): begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == '0)
                        state <= last_q ? ST_FLUSH : ST_IDLE;
                end
                (state == ST_FLUSH): begin
                    state      <= ST_IDLE;
                    frame_open <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating counter; clear wins over a coincident hit
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_count <= '0;
            thresh_hit  <= 1'b0;
        end else if (clr_count) begin
            match_count <= '0;
            thresh_hit  <= 1'b0;
        end else if (hit && (match_count != '1)) begin
            match_count <= cnt_inc;
            if ((cfg_thresh != '0) && (cnt_inc == cfg_thresh))
                thresh_hit <= 1'b1;
        end
    end

    pattern_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .data_bit (bit_out),
        .valid    (bit_valid),
        .pattern  (pat_q),
        .overlap  (ovl_q),
        .clear    (done),
        .hit      (hit),
        .match    (match)
    );

endmodule
